// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// The optional build switch UART_ARB_FIXED_PRIO_EN (see uart_arb_pick)
// replaces round-robin arbitration with fixed lowest-index priority.
package uart_arb_pkg;

    // IDLE: arbitrating, nothing forwarded. XFER: one packet owns the UART.
    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    // Default parameter values.
    localparam int DEF_NUM_REQ      = 2;
    localparam int DEF_DATA_W       = 8;
    localparam int DEF_MAX_PKT_LEN  = 64;
    localparam int DEF_IDLE_TIMEOUT = 1024;

    // One counter width serves both the beat and the idle counter; the extra
    // bit lets each counter reach its limit value without wrapping.
    function automatic int cnt_width(input int max_len, input int idle_to);
        return $clog2((max_len > idle_to) ? max_len : idle_to) + 1;
    endfunction

    // Widths for the default configuration.
    localparam int ID_W  = $clog2(DEF_NUM_REQ);
    localparam int CNT_W = cnt_width(DEF_MAX_PKT_LEN, DEF_IDLE_TIMEOUT);

endpackage

// File: rtl/uart_arb_pick.sv
// Winner selection for the UART transmit arbiter (purely combinational).
// Default: round-robin, first requester at or after rr_ptr, wrapping.
// With UART_ARB_FIXED_PRIO_EN defined: lowest asserted index wins and
// rr_ptr is ignored.
module uart_arb_pick
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int SEL_W   = ID_W
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   rr_ptr,
    output logic [SEL_W-1:0]   winner,
    output logic               any_req
);

`ifdef UART_ARB_FIXED_PRIO_EN
    // Pointer has no meaning under fixed priority.
    logic unused_rr_ptr;
    assign unused_rr_ptr = ^rr_ptr;

    // Scan from the top down so the lowest asserted index is the last write.
    always_comb begin
        winner  = '0;
        any_req = |req;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                winner = SEL_W'(k);
            end
        end
    end
`else
    int idx;

    // Scan offsets from farthest to nearest so the requester closest to
    // rr_ptr (in wrapping order) is the last write and therefore wins.
    always_comb begin
        winner  = '0;
        any_req = |req;
        idx     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req[idx]) begin
                winner = SEL_W'(idx);
            end
        end
    end
`endif

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular arbiter sharing one UART TX byte stream between NUM_REQ
// sources. Whole packets are granted (never interleaved); a packet whose
// owner stalls for IDLE_TIMEOUT cycles or runs MAX_PKT_LEN beats without a
// last beat is force-released with a one-cycle abort_pulse.
// Build option UART_ARB_FIXED_PRIO_EN selects fixed lowest-index priority.
//
// Handshake: a beat moves on a clk edge where valid and ready are both high.
// In XFER the owner's valid/data drive tx_valid/tx_data directly and
// tx_ready drives the owner's req_ready; all other req_ready bits stay low.
// Valid may drop mid-packet; that counts toward the idle timeout, while
// tx_ready low with valid high is backpressure and does not.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int MAX_PKT_LEN  = DEF_MAX_PKT_LEN,
    parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        tx_valid,
    output logic [DATA_W-1:0]           tx_data,
    input  logic                        tx_ready,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy,
    output logic                        abort_pulse,
    output logic                        dbg_state
);

    localparam int GID_W = $clog2(NUM_REQ);
    localparam int CW    = cnt_width(MAX_PKT_LEN, IDLE_TIMEOUT);
    localparam logic [CW-1:0] MAX_BEATS  = CW'(MAX_PKT_LEN);
    localparam logic [CW-1:0] IDLE_LIMIT = CW'(IDLE_TIMEOUT);

    arb_state_e        state_q, state_d;
    logic [GID_W-1:0]  grant_q, grant_d;
    logic [GID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]     beat_cnt_q, beat_cnt_d;
    logic [CW-1:0]     idle_cnt_q, idle_cnt_d;
    logic              abort_q, abort_d;

    logic [GID_W-1:0]  winner;
    logic              any_req;
    logic              sel_valid;
    logic              sel_last;
    logic [DATA_W-1:0] sel_data;
    logic              beat;
    logic              pkt_end;

    // Next owner after g in wrapping order.
    function automatic logic [GID_W-1:0] next_id(input logic [GID_W-1:0] id);
        if (int'(id) == NUM_REQ - 1) begin
            return '0;
        end
        return id + 1'b1;
    endfunction

    uart_arb_pick #(
        .NUM_REQ (NUM_REQ),
        .SEL_W   (GID_W)
    ) u_pick (
        .req     (req_valid),
        .rr_ptr  (rr_ptr_q),
        .winner  (winner),
        .any_req (any_req)
    );

    assign sel_valid = req_valid[grant_q];
    assign sel_last  = req_last[grant_q];
    assign sel_data  = req_data[int'(grant_q)*DATA_W +: DATA_W];
    assign beat      = sel_valid & tx_ready;

    assign grant_id    = grant_q;
    assign busy        = (state_q == XFER);
    assign abort_pulse = abort_q;
    assign dbg_state   = state_q;

    // State, owner, pointer and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            idle_cnt_q <= '0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            abort_q    <= abort_d;
        end
    end

    // Arbitration, pass-through muxing, counters and release/abort decisions.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        idle_cnt_d = idle_cnt_q;
        abort_d    = 1'b0;
        pkt_end    = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = '0;
        req_ready  = '0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = winner;
                    state_d = XFER;
                end
            end
            XFER: begin
                tx_valid           = sel_valid;
                tx_data            = sel_data;
                req_ready[grant_q] = tx_ready;
                idle_cnt_d = sel_valid ? '0 : (idle_cnt_q + 1'b1);
                if (beat && sel_last) begin
                    // Normal completion wins over any limit reached this cycle.
                    pkt_end = 1'b1;
                end else begin
                    if (beat) begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                    if ((beat_cnt_d == MAX_BEATS) || (idle_cnt_d == IDLE_LIMIT)) begin
                        pkt_end = 1'b1;
                        abort_d = 1'b1;
                    end
                end
                if (pkt_end) begin
                    state_d    = IDLE;
                    beat_cnt_d = '0;
                    idle_cnt_d = '0;
`ifdef UART_ARB_FIXED_PRIO_EN
                    rr_ptr_d   = '0;
`else
                    rr_ptr_d   = next_id(grant_q);
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (NUM_REQ=2, MAX_PKT_LEN=4,
// IDLE_TIMEOUT=16). Honors UART_ARB_FIXED_PRIO_EN for its expectations.
module tb_uart_tx_arbiter;

    localparam int NR  = 2;
    localparam int DW  = 8;
    localparam int MPL = 4;
    localparam int ITO = 16;

    logic                    clk;
    logic                    reset_n;
    logic [NR-1:0]           req_valid;
    logic [NR*DW-1:0]        req_data;
    logic [NR-1:0]           req_last;
    logic [NR-1:0]           req_ready;
    logic                    tx_valid;
    logic [DW-1:0]           tx_data;
    logic                    tx_ready;
    logic [$clog2(NR)-1:0]   grant_id;
    logic                    busy;
    logic                    abort_pulse;
    logic                    dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_arbiter #(
        .NUM_REQ      (NR),
        .DATA_W       (DW),
        .MAX_PKT_LEN  (MPL),
        .IDLE_TIMEOUT (ITO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .grant_id    (grant_id),
        .busy        (busy),
        .abort_pulse (abort_pulse),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b0;
    endtask

    task automatic drive_req(input int i, input logic v, input logic [7:0] d, input logic l);
        req_valid[i]       = v;
        req_data[i*DW +: DW] = d;
        req_last[i]        = l;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ---------------- table-driven vectors ----------------
    typedef struct {
        logic [1:0] v;
        logic [7:0] d0;
        logic       l0;
        logic [7:0] d1;
        logic       l1;
        logic       rdy;
        logic       e_txv;
        logic [7:0] e_txd;
        logic [1:0] e_rdy;
        logic       e_busy;
        logic       e_gid;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] d0, input logic l0, input logic [7:0] d1,
                                input logic l1, input logic e_txv, input logic [7:0] e_txd,
                                input logic [1:0] e_rdy, input logic e_busy, input logic e_gid);
        vec_t r;
        r.v = 2'b11; r.rdy = 1'b1;
        r.d0 = d0; r.l0 = l0; r.d1 = d1; r.l1 = l1;
        r.e_txv = e_txv; r.e_txd = e_txd; r.e_rdy = e_rdy; r.e_busy = e_busy; r.e_gid = e_gid;
        return r;
    endfunction

    vec_t vecs[14];

    // ---------------- reference model + scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    logic [8:0]    src_q[NR][$];   // {last, data} per requester
    int            hold[NR];
    int            m_owner, m_rr, m_beats, m_stall;
    logic          m_abort;

    function automatic int model_pick(input logic [NR-1:0] v, input int rr);
`ifdef UART_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NR; i++) if (v[i]) return i;
`else
        for (int k = 0; k < NR; k++) if (v[(rr + k) % NR]) return (rr + k) % NR;
`endif
        return -1;
    endfunction

    task automatic gen_packet(input int i);
        int len;
        len = $urandom_range(1, 6);
        for (int j = 0; j < len; j++) begin
            src_q[i].push_back({(j == len - 1), 8'($urandom_range(0, 255))});
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] e_txd_l[10];
        logic       e_busy_l[10], e_txv_l[10], e_gid_l[10], e_ab_l[10];
        int idx, k, i0;
        logic r1_done;

        clear_inputs();
        reset_n = 1'b0;

        // Reset state.
        @(negedge clk); #1;
        check("rst_busy", busy, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_abort", abort_pulse, 0);
        check("rst_dbg_state", dbg_state, 0);

        // Round-robin fairness table (both requesters sending 3-byte packets).
        vecs[0]  = mk(8'h41, 0, 8'h61, 0, 0, 8'h00, 2'b00, 0, 0);
        vecs[1]  = mk(8'h41, 0, 8'h61, 0, 1, 8'h41, 2'b01, 1, 0);
        vecs[2]  = mk(8'h42, 0, 8'h61, 0, 1, 8'h42, 2'b01, 1, 0);
        vecs[3]  = mk(8'h43, 1, 8'h61, 0, 1, 8'h43, 2'b01, 1, 0);
        vecs[4]  = mk(8'h41, 0, 8'h61, 0, 0, 8'h00, 2'b00, 0, 0);
`ifdef UART_ARB_FIXED_PRIO_EN
        vecs[5]  = mk(8'h41, 0, 8'h61, 0, 1, 8'h41, 2'b01, 1, 0);
        vecs[6]  = mk(8'h42, 0, 8'h61, 0, 1, 8'h42, 2'b01, 1, 0);
        vecs[7]  = mk(8'h43, 1, 8'h61, 0, 1, 8'h43, 2'b01, 1, 0);
        vecs[8]  = mk(8'h41, 0, 8'h61, 0, 0, 8'h00, 2'b00, 0, 0);
        vecs[9]  = mk(8'h41, 0, 8'h61, 0, 1, 8'h41, 2'b01, 1, 0);
        vecs[10] = mk(8'h42, 0, 8'h61, 0, 1, 8'h42, 2'b01, 1, 0);
        vecs[11] = mk(8'h43, 1, 8'h61, 0, 1, 8'h43, 2'b01, 1, 0);
        vecs[12] = mk(8'h41, 0, 8'h61, 0, 0, 8'h00, 2'b00, 0, 0);
        vecs[13] = mk(8'h41, 0, 8'h61, 0, 1, 8'h41, 2'b01, 1, 0);
`else
        vecs[5]  = mk(8'h41, 0, 8'h61, 0, 1, 8'h61, 2'b10, 1, 1);
        vecs[6]  = mk(8'h41, 0, 8'h62, 0, 1, 8'h62, 2'b10, 1, 1);
        vecs[7]  = mk(8'h41, 0, 8'h63, 1, 1, 8'h63, 2'b10, 1, 1);
        vecs[8]  = mk(8'h41, 0, 8'h61, 0, 0, 8'h00, 2'b00, 0, 0);
        vecs[9]  = mk(8'h41, 0, 8'h61, 0, 1, 8'h41, 2'b01, 1, 0);
        vecs[10] = mk(8'h42, 0, 8'h61, 0, 1, 8'h42, 2'b01, 1, 0);
        vecs[11] = mk(8'h43, 1, 8'h61, 0, 1, 8'h43, 2'b01, 1, 0);
        vecs[12] = mk(8'h41, 0, 8'h61, 0, 0, 8'h00, 2'b00, 0, 0);
        vecs[13] = mk(8'h41, 0, 8'h61, 0, 1, 8'h61, 2'b10, 1, 1);
`endif
        do_reset();
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive_req(0, vecs[i].v[0], vecs[i].d0, vecs[i].l0);
            drive_req(1, vecs[i].v[1], vecs[i].d1, vecs[i].l1);
            tx_ready = vecs[i].rdy;
            #1;
            check($sformatf("rr%0d_tx_valid", i), tx_valid, vecs[i].e_txv);
            if (vecs[i].e_txv) check($sformatf("rr%0d_tx_data", i), tx_data, vecs[i].e_txd);
            check($sformatf("rr%0d_req_ready", i), req_ready, vecs[i].e_rdy);
            check($sformatf("rr%0d_busy", i), busy, vecs[i].e_busy);
            check($sformatf("rr%0d_dbg_state", i), dbg_state, vecs[i].e_busy);
            if (vecs[i].e_busy) check($sformatf("rr%0d_grant_id", i), grant_id, vecs[i].e_gid);
            check($sformatf("rr%0d_abort", i), abort_pulse, 0);
        end

        // Backpressure: tx_ready toggles 1,0,1,... during a 4-byte packet.
        do_reset();
        @(negedge clk);
        tx_ready = 1'b1;
        drive_req(0, 1, 8'hB0, 0);
        #1;
        check("bp_idle_busy", busy, 0);
        idx = 0; k = 0;
        while (idx < 4 && k < 20) begin
            @(negedge clk);
            tx_ready = (k % 2 == 0);
            drive_req(0, 1, 8'(8'hB0 + idx), (idx == 3));
            #1;
            check("bp_tx_valid", tx_valid, 1);
            check("bp_tx_data", tx_data, 8'(8'hB0 + idx));
            check("bp_req_ready", req_ready, {1'b0, tx_ready});
            check("bp_busy", busy, 1);
            check("bp_abort", abort_pulse, 0);
            if (tx_valid && tx_ready && req_ready[0]) idx++;
            k++;
        end
        check("bp_cycles", k, 7);
        @(negedge clk);
        drive_req(0, 0, 8'h00, 0);
        #1;
        check("bp_end_busy", busy, 0);
        check("bp_end_abort", abort_pulse, 0);

        // Idle timeout: requester 1 sends one byte then stalls.
        do_reset();
        tx_ready = 1'b1;
        @(negedge clk);
        drive_req(1, 1, 8'h55, 0);
        #1;
        check("ito_c0_busy", busy, 0);
        @(negedge clk);
        drive_req(0, 1, 8'h30, 1);
        #1;
        check("ito_c1_grant", grant_id, 1);
        check("ito_c1_tx_data", tx_data, 8'h55);
        for (int c = 0; c < ITO; c++) begin
            @(negedge clk);
            drive_req(1, 0, 8'h00, 0);
            #1;
            check($sformatf("ito_stall%0d_abort", c), abort_pulse, 0);
            check($sformatf("ito_stall%0d_busy", c), busy, 1);
            check($sformatf("ito_stall%0d_ready", c), req_ready, 2'b10);
        end
        @(negedge clk); #1;
        check("ito_pulse_abort", abort_pulse, 1);
        check("ito_pulse_busy", busy, 0);
        @(negedge clk); #1;
        check("ito_next_abort", abort_pulse, 0);
        check("ito_next_busy", busy, 1);
        check("ito_next_grant", grant_id, 0);
        check("ito_next_tx_data", tx_data, 8'h30);
        @(negedge clk);
        drive_req(0, 0, 8'h00, 0);
        #1;
        check("ito_done_busy", busy, 0);

        // Length cap: requester 0 sends 6 bytes with no last; requester 1
        // raises a single-byte packet when the abort happens.
        e_ab_l = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
`ifdef UART_ARB_FIXED_PRIO_EN
        e_busy_l = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1};
        e_txv_l  = '{0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
        e_gid_l  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        e_txd_l  = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h13, 8'h00, 8'h14, 8'h15, 8'h00, 8'h00};
`else
        e_busy_l = '{0, 1, 1, 1, 1, 0, 1, 0, 1, 1};
        e_txv_l  = '{0, 1, 1, 1, 1, 0, 1, 0, 1, 1};
        e_gid_l  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        e_txd_l  = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h13, 8'h00, 8'h77, 8'h00, 8'h14, 8'h15};
`endif
        do_reset();
        tx_ready = 1'b1;
        i0 = 0; r1_done = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            drive_req(0, (i0 < 6), 8'(8'h10 + i0), 0);
            drive_req(1, (c >= 5) && !r1_done, 8'h77, 1);
            #1;
            check($sformatf("len%0d_abort", c), abort_pulse, e_ab_l[c]);
            check($sformatf("len%0d_busy", c), busy, e_busy_l[c]);
            check($sformatf("len%0d_tx_valid", c), tx_valid, e_txv_l[c]);
            if (e_busy_l[c]) check($sformatf("len%0d_grant", c), grant_id, e_gid_l[c]);
            if (e_txv_l[c]) check($sformatf("len%0d_tx_data", c), tx_data, e_txd_l[c]);
            if (req_valid[0] && req_ready[0]) i0++;
            if (req_valid[1] && req_ready[1]) r1_done = 1'b1;
        end

        // Reset mid-packet: requester 1 owns the UART when reset hits.
        do_reset();
        tx_ready = 1'b1;
        @(negedge clk);
        drive_req(0, 1, 8'h01, 1);
        @(negedge clk);
        #1;
        check("mrst_first_tx", tx_data, 8'h01);
        @(negedge clk);
        drive_req(0, 0, 8'h00, 0);
        drive_req(1, 1, 8'h61, 0);
        @(negedge clk);
        #1;
        check("mrst_owner1_grant", grant_id, 1);
        check("mrst_owner1_data", tx_data, 8'h61);
        @(negedge clk);
        drive_req(1, 1, 8'h62, 0);
        #1;
        check("mrst_pre_tx_valid", tx_valid, 1);
        #1;
        reset_n = 1'b0;
        #1;
        check("mrst_tx_valid", tx_valid, 0);
        check("mrst_busy", busy, 0);
        check("mrst_grant", grant_id, 0);
        check("mrst_ready", req_ready, 0);
        @(negedge clk);
        reset_n = 1'b1;
        drive_req(0, 1, 8'h02, 1);
        #1;
        check("mrst_rel_busy", busy, 0);
        @(negedge clk);
        #1;
        check("mrst_regrant_busy", busy, 1);
        check("mrst_regrant_grant", grant_id, 0);
        check("mrst_regrant_data", tx_data, 8'h02);

        // Randomized traffic against the packet-level model.
        do_reset();
        m_owner = -1; m_rr = 0; m_beats = 0; m_stall = 0; m_abort = 1'b0;
        for (int i = 0; i < NR; i++) begin
            src_q[i].delete();
            hold[i] = 0;
        end
        exp_q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [NR-1:0] e_rdy;
            logic          e_busy, e_txv, beat, was_last, abort_next;
            int            g, w, r;
            @(negedge clk);
            for (int i = 0; i < NR; i++) begin
                if (src_q[i].size() == 0) gen_packet(i);
                if (hold[i] > 0) begin
                    hold[i]--;
                    req_valid[i] = 1'b0;
                end else begin
                    req_valid[i] = 1'b1;
                    r = $urandom_range(0, 99);
                    if (r < 8) hold[i] = $urandom_range(1, 4);
                    else if (r < 9) hold[i] = $urandom_range(ITO, ITO + 4);
                end
                {req_last[i], req_data[i*DW +: DW]} = src_q[i][0];
            end
            tx_ready = ($urandom_range(0, 3) != 0);
            #1;
            e_rdy = '0;
            if (m_owner < 0) begin
                e_busy = 1'b0;
                e_txv  = 1'b0;
            end else begin
                e_busy = 1'b1;
                e_txv  = req_valid[m_owner];
                e_rdy[m_owner] = tx_ready;
            end
            check("rnd_busy", busy, e_busy);
            check("rnd_tx_valid", tx_valid, e_txv);
            check("rnd_req_ready", req_ready, e_rdy);
            check("rnd_abort", abort_pulse, m_abort);
            if (e_busy) check("rnd_grant", grant_id, m_owner);

            // Model a transfer of the owner's head byte and score the DUT's.
            beat = (m_owner >= 0) && req_valid[m_owner] && tx_ready;
            was_last = 1'b0;
            if (beat) begin
                exp_q.push_back(src_q[m_owner][0][7:0]);
                was_last = src_q[m_owner][0][8];
                void'(src_q[m_owner].pop_front());
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) check("rnd_tx_extra", 1, 0);
                else check("rnd_tx_data", tx_data, exp_q.pop_front());
            end

            // Packet-level ownership rules.
            abort_next = 1'b0;
            if (m_owner < 0) begin
                w = model_pick(req_valid, m_rr);
                if (w >= 0) m_owner = w;
            end else begin
                g = m_owner;
                m_stall = req_valid[g] ? 0 : m_stall + 1;
                if (beat && !was_last) m_beats++;
                if ((beat && was_last) || m_beats == MPL || m_stall == ITO) begin
                    abort_next = !(beat && was_last);
                    m_owner = -1;
`ifdef UART_ARB_FIXED_PRIO_EN
                    m_rr = 0;
`else
                    m_rr = (g + 1) % NR;
`endif
                    m_beats = 0;
                    m_stall = 0;
                end
            end
            m_abort = abort_next;
        end
        check("rnd_exp_q_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
